// File: rtl/dmi_jtag_host.sv
// JTAG scan host: turns DR/IR/TAP-reset requests into TCK/TMS/TDI sequences
// and returns the bits captured from TDO. The TAP is assumed to start in Run-Test/Idle.
module dmi_jtag_host #(
   parameter int unsigned ClkDiv = 2,
   parameter int unsigned MaxLen = 41,
   localparam int unsigned LenW  = $clog2(MaxLen + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [LenW-1:0]   req_len_i,
   input  logic [MaxLen-1:0] req_data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [MaxLen-1:0] rsp_data_o,
   output logic              tck_o,
   output logic              tms_o,
   output logic              td_o,
   output logic              trst_no,
   input  logic              td_i
);

   localparam int unsigned CntW = (LenW < 3) ? 3 : LenW;
   localparam logic [1:0] OpDr = 2'd0;
   localparam logic [1:0] OpIr = 2'd1;

   typedef enum logic [2:0] {IDLE, HEAD, SHIFT, TAIL, RESP} state_e;

   state_e            state_q;
   logic [1:0]        op_q;
   logic [CntW-1:0]   len_q;
   logic [MaxLen-1:0] data_q;
   logic [MaxLen-1:0] rsp_q;
   logic [CntW-1:0]   cnt_q;
   logic [7:0]        div_q;
   logic              hi_q;
   logic              tck_q;
   logic              tms_q;
   logic              td_q;
   logic              ready_q;
   logic              rsp_valid_q;

   logic [CntW-1:0]   cnt_d;
   logic [CntW-1:0]   len_d;
   logic              phase_end;

   // Index of the last TMS bit of the head sequence (TAP reset runs 6 bits, then ends).
   function automatic logic [CntW-1:0] head_last(input logic [1:0] op);
      case (op)
         OpDr:    head_last = CntW'(2);
         OpIr:    head_last = CntW'(3);
         default: head_last = CntW'(5);
      endcase
   endfunction

   function automatic logic head_tms(input logic [1:0] op, input logic [CntW-1:0] idx);
      case (op)
         OpDr:    head_tms = (idx == '0);
         OpIr:    head_tms = (idx < CntW'(2));
         default: head_tms = (idx < CntW'(5));
      endcase
   endfunction

   assign cnt_d     = cnt_q + CntW'(1);
   assign phase_end = (div_q == 8'(ClkDiv - 1));

   always_comb begin
      len_d = CntW'(req_len_i);
      if (req_len_i == '0) begin
         len_d = CntW'(1);
      end else if (req_len_i > LenW'(MaxLen)) begin
         len_d = CntW'(MaxLen);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         op_q        <= '0;
         len_q       <= '0;
         data_q      <= '0;
         rsp_q       <= '0;
         cnt_q       <= '0;
         div_q       <= '0;
         hi_q        <= 1'b0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         td_q        <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  op_q    <= req_op_i;
                  len_q   <= len_d;
                  data_q  <= req_data_i;
                  rsp_q   <= '0;
                  cnt_q   <= '0;
                  div_q   <= '0;
                  hi_q    <= 1'b0;
                  tck_q   <= 1'b0;
                  tms_q   <= 1'b1;
                  td_q    <= 1'b0;
                  ready_q <= 1'b0;
                  state_q <= HEAD;
               end
            end
            HEAD, SHIFT, TAIL: begin
               if (!phase_end) begin
                  div_q <= div_q + 8'd1;
               end else begin
                  div_q <= '0;
                  if (!hi_q) begin
                     // Rising TCK: TDO was launched on the previous falling edge.
                     hi_q  <= 1'b1;
                     tck_q <= 1'b1;
                     if (state_q == SHIFT) rsp_q[cnt_q] <= td_i;
                  end else begin
                     // Falling TCK starts the next bit: TMS/TDI update here only.
                     hi_q  <= 1'b0;
                     tck_q <= 1'b0;
                     if (state_q == HEAD) begin
                        if (cnt_q == head_last(op_q)) begin
                           cnt_q <= '0;
                           if (op_q[1]) begin
                              state_q     <= RESP;
                              rsp_valid_q <= 1'b1;
                           end else begin
                              state_q <= SHIFT;
                              tms_q   <= (len_q == CntW'(1));
                              td_q    <= data_q[0];
                           end
                        end else begin
                           cnt_q <= cnt_d;
                           tms_q <= head_tms(op_q, cnt_d);
                        end
                     end else if (state_q == SHIFT) begin
                        if (cnt_q == len_q - CntW'(1)) begin
                           state_q <= TAIL;
                           cnt_q   <= '0;
                           tms_q   <= 1'b1;
                           td_q    <= 1'b0;
                        end else begin
                           cnt_q <= cnt_d;
                           td_q  <= data_q[cnt_d];
                           tms_q <= (cnt_d == len_q - CntW'(1));
                        end
                     end else begin
                        if (cnt_q == '0) begin
                           cnt_q <= CntW'(1);
                           tms_q <= 1'b0;
                        end else begin
                           cnt_q       <= '0;
                           state_q     <= RESP;
                           rsp_valid_q <= 1'b1;
                        end
                     end
                  end
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_q;
   assign tck_o       = tck_q;
   assign tms_o       = tms_q;
   assign td_o        = td_q;
   assign trst_no     = rst_ni;

endmodule

// File: doc/dmi_jtag_host.md
DMI_JTAG_HOST -- requirements
Module: dmi_jtag_host

Interface
REQ-001 SHALL have parameter ClkDiv, default 2, meaning TCK half-period in clk_i cycles (legal 1..255).
REQ-002 SHALL have parameter MaxLen, default 41, meaning maximum scan length in bits (DMI 7+32+2).
REQ-003 SHALL have port clk_i  input  1  system clock; single clock domain, all logic on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i  input  1  scan request valid.
REQ-006 SHALL have port req_ready_o  output  1  host idle and able to accept a request.
REQ-007 SHALL have port req_op_i  input  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=reserved (treated as TAP reset).
REQ-008 SHALL have port req_len_i  input  $clog2(MaxLen+1)  scan length in bits; 0 treated as 1, >MaxLen clamped to MaxLen.
REQ-009 SHALL have port req_data_i  input  MaxLen  bits shifted into TDI, LSB first.
REQ-010 SHALL have port rsp_valid_o  output  1  response valid.
REQ-011 SHALL have port rsp_ready_i  input  1  response accepted.
REQ-012 SHALL have port rsp_data_o  output  MaxLen  bits captured from TDO, bit i = i-th bit shifted out, upper unused bits 0.
REQ-013 SHALL have ports tck_o, tms_o, td_o, trst_no  output  1 each  JTAG pins towards the TAP.
REQ-014 SHALL have port td_i  input  1  TDO from the TAP.

Function
REQ-015 TCK SHALL be generated by a divider: one TCK period = 2*ClkDiv clk_i cycles, low phase first; tck_o SHALL stay low when no TCK cycle is in progress.
REQ-016 tms_o and td_o SHALL change only at the start of a TCK low phase and hold through the following rising edge.
REQ-017 td_i SHALL be sampled in the clk_i cycle in which tck_o rises (register of TCK rising edge).
REQ-018 Handshake: request accepted when req_valid_i && req_ready_o; req_op/len/data SHALL be registered on acceptance; req_ready_o SHALL be high only in IDLE.
REQ-019 FSM states: IDLE, HEAD, SHIFT, TAIL, RESP.
REQ-020 HEAD SHALL emit TMS sequence 1,0,0 for DR scan and 1,1,0,0 for IR scan, starting from Run-Test/Idle; TAP reset emits 1,1,1,1,1 then 0 and goes to RESP with rsp_data_o = 0.
REQ-021 SHIFT SHALL emit len TCK cycles, td_o = data[i], tms_o = 0 except 1 on the last bit (exit to Exit1); td_i sampled on cycle i stored in rsp bit i.
REQ-022 TAIL SHALL emit TMS 1,0 (Update, Run-Test/Idle); td_o SHALL be 0 outside SHIFT.
REQ-023 RESP SHALL hold rsp_valid_o high and rsp_data_o stable until rsp_ready_i; transition to IDLE on the handshake cycle; req_ready_o rises the following cycle.
REQ-024 Total TCK cycles: DR = len+5, IR = len+6, TAP reset = 6.
REQ-025 req_valid_i while busy SHALL be ignored (not accepted, no side effects).
REQ-026 trst_no SHALL equal 1 whenever rst_ni is high; it is 0 only while rst_ni is low.

Reset
REQ-027 On rst_ni low: state IDLE, tck_o=0, tms_o=1, td_o=0, trst_no=0, req_ready_o=1 after release, rsp_valid_o=0, rsp_data_o=0, divider and bit counters 0.
REQ-028 Reset asserted mid-scan SHALL abort immediately with outputs at reset values; no response is produced; software issues a TAP reset op before the next scan.
REQ-029 First operation after reset SHALL be a TAP reset op; the host does not itself track TAP state.

Verification
REQ-030 TAP reset op, ClkDiv=2 -> exactly 6 TCK pulses, 20-cycle-period-free spacing of 4 clk_i, TMS 1,1,1,1,1,0, rsp_data_o=0.
REQ-031 IR scan len=5 data=0x11 against TAP model -> TMS 1,1,0,0,0,0,0,0,1,1,0; rsp_data_o=0x01 (capture pattern).
REQ-032 DR scan len=32 after IR=IDCODE, IdcodeValue=0x00000001 -> rsp_data_o=0x00000001, 37 TCK cycles.
REQ-033 DR scan len=1 in BYPASS, data=1 -> rsp bit0=0, TMS 1,0,0,1,1,0.
REQ-034 Hold rsp_ready_i low 10 cycles -> rsp_valid_o and data stable, req_ready_o low; second req_valid_i during scan not accepted.
REQ-035 rst_ni low at SHIFT bit 10 of 41 -> tck_o=0, rsp_valid_o=0 next cycle, req_ready_o=1 after release.
